// File: rtl/vpf_inject_gen.sv
// Synthetic valid-pattern-flag source: builds a 768-strip hit pattern one hit per clock and
// emits it as a one-cycle frame tagged with its exact distinct-hit count and overflow flag.
module vpf_inject_gen #(
  parameter int unsigned NSTRIPS         = 768,
  parameter int unsigned MAX_HITS        = 16,
  parameter int unsigned OVERFLOW_THRESH = 0
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start_i,
  input  logic               stop_i,
  input  logic [4:0]         nhits_i,
  input  logic [9:0]         base_i,
  input  logic [9:0]         stride_i,
  input  logic [9:0]         base_step_i,
  input  logic [15:0]        npatterns_i,
  input  logic [7:0]         gap_i,
  output logic [NSTRIPS-1:0] vpfs_o,
  output logic               valid_o,
  output logic [10:0]        expected_cnt_o,
  output logic               expected_ovf_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int unsigned POS_W = 10;
  localparam int unsigned CNT_W = 11;
  localparam logic [POS_W-1:0] LAST_STRIP = POS_W'(NSTRIPS - 1);
  localparam logic [POS_W:0]   NSTRIPS_C  = (POS_W + 1)'(NSTRIPS);
  localparam logic [4:0]       MAX_HITS_C = 5'(MAX_HITS);
  localparam logic [CNT_W-1:0] OVF_C      = CNT_W'(OVERFLOW_THRESH);

  typedef enum logic [1:0] {IDLE, BUILD, EMIT, GAP} state_t;

  state_t             state;
  logic [4:0]         cfg_nhits;
  logic [POS_W-1:0]   cfg_stride;
  logic [POS_W-1:0]   cfg_step;
  logic [15:0]        cfg_npat;
  logic [7:0]         cfg_gap;
  logic [POS_W-1:0]   base_q;
  logic [POS_W-1:0]   pos;
  logic [4:0]         k;
  logic [CNT_W-1:0]   distinct;
  logic [15:0]        sent;
  logic [7:0]         gap_cnt;
  logic [NSTRIPS-1:0] shadow;

  logic [POS_W-1:0]   base_nxt;
  logic [15:0]        sent_inc;

  // Strip addition modulo NSTRIPS; both operands are already below NSTRIPS.
  function automatic logic [POS_W-1:0] wrap_add(input logic [POS_W-1:0] a,
                                                input logic [POS_W-1:0] b);
    logic [POS_W:0] s;
    s = (POS_W + 1)'(a) + (POS_W + 1)'(b);
    if (s >= NSTRIPS_C) s = s - NSTRIPS_C;
    return s[POS_W-1:0];
  endfunction

  function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] x);
    return (x > LAST_STRIP) ? LAST_STRIP : x;
  endfunction

  assign base_nxt = wrap_add(base_q, cfg_step);
  assign sent_inc = sent + 16'd1;

  // Frame sequencer; stop_i overrides every transition.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cfg_nhits      <= '0;
      cfg_stride     <= '0;
      cfg_step       <= '0;
      cfg_npat       <= '0;
      cfg_gap        <= '0;
      base_q         <= '0;
      pos            <= '0;
      k              <= '0;
      distinct       <= '0;
      sent           <= '0;
      gap_cnt        <= '0;
      shadow         <= '0;
      vpfs_o         <= '0;
      valid_o        <= 1'b0;
      expected_cnt_o <= '0;
      expected_ovf_o <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      done_o  <= 1'b0;
      vpfs_o  <= '0;
      busy_o  <= (state != IDLE);
      if (stop_i) begin
        state  <= IDLE;
        busy_o <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start_i) begin
              cfg_nhits  <= (nhits_i > MAX_HITS_C) ? MAX_HITS_C : nhits_i;
              cfg_stride <= clamp_pos(stride_i);
              cfg_step   <= clamp_pos(base_step_i);
              cfg_npat   <= npatterns_i;
              cfg_gap    <= gap_i;
              base_q     <= clamp_pos(base_i);
              pos        <= clamp_pos(base_i);
              k          <= '0;
              distinct   <= '0;
              sent       <= '0;
              shadow     <= '0;
              state      <= BUILD;
            end
          end
          BUILD: begin
            if (k < cfg_nhits) begin
              shadow[pos] <= 1'b1;
              if (!shadow[pos]) distinct <= distinct + CNT_W'(1);
              k   <= k + 5'd1;
              pos <= wrap_add(pos, cfg_stride);
            end else begin
              state <= EMIT;
            end
          end
          EMIT: begin
            valid_o        <= 1'b1;
            vpfs_o         <= shadow;
            expected_cnt_o <= distinct;
            expected_ovf_o <= (distinct > OVF_C);
            sent           <= sent_inc;
            base_q         <= base_nxt;
            if ((cfg_npat != 16'd0) && (sent_inc == cfg_npat)) begin
              done_o <= 1'b1;
              state  <= IDLE;
            end else begin
              shadow   <= '0;
              k        <= '0;
              distinct <= '0;
              pos      <= base_nxt;
              if (cfg_gap != 8'd0) begin
                gap_cnt <= cfg_gap;
                state   <= GAP;
              end else begin
                state <= BUILD;
              end
            end
          end
          GAP: begin
            if (gap_cnt == 8'd1) state <= BUILD;
            else gap_cnt <= gap_cnt - 8'd1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
